// File: rtl/gate_lane_pipe_if.sv
// Handshake bundle for gate_lane_pipe: source side (in_*) and sink side (out_*, xfer_cnt).
// out_par is present only when GATE_LANE_PIPE_PARITY_EN is defined.
interface gate_lane_pipe_if #(
    parameter int unsigned CH    = 4,
    parameter int unsigned W     = 8,
    parameter int unsigned CNT_W = 16
);
    logic                 in_valid;
    logic                 in_ready;
    logic [1:0]           in_op;
    logic [CH-1:0][W-1:0] in_a;
    logic [CH-1:0][W-1:0] in_b;
    logic                 out_valid;
    logic                 out_ready;
    logic [CH-1:0][W-1:0] out_data;
    logic [CNT_W-1:0]     xfer_cnt;
`ifdef GATE_LANE_PIPE_PARITY_EN
    logic [CH-1:0]        out_par;

    modport master (
        output in_valid, in_op, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_data, xfer_cnt, out_par
    );
    modport slave (
        input  in_valid, in_op, in_a, in_b, out_ready,
        output in_ready, out_valid, out_data, xfer_cnt, out_par
    );
`else
    modport master (
        output in_valid, in_op, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_data, xfer_cnt
    );
    modport slave (
        input  in_valid, in_op, in_a, in_b, out_ready,
        output in_ready, out_valid, out_data, xfer_cnt
    );
`endif
endinterface

// File: rtl/gate_lane_pipe.sv
// Lane-wise AND/OR/XOR/NOT gate feeding a DEPTH-entry result FIFO with a registered head.
// Optional per-lane head parity output under GATE_LANE_PIPE_PARITY_EN.
module gate_lane_pipe #(
    parameter int unsigned CH    = 4,
    parameter int unsigned W     = 8,
    parameter int unsigned DEPTH = 2,
    parameter int unsigned CNT_W = 16
) (
    input logic             clk,
    input logic             rst,
    gate_lane_pipe_if.slave bus
);
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    typedef logic [CH-1:0][W-1:0] lane_t;

    lane_t            r_mem [DEPTH];
    lane_t            r_head;
    logic [PW-1:0]    r_wptr;
    logic [PW-1:0]    r_rptr;
    logic [CW-1:0]    r_count;
    logic [CNT_W-1:0] r_xfer_cnt;

    lane_t            w_res;
    lane_t            w_head_d;
    logic [PW-1:0]    w_wptr_d;
    logic [PW-1:0]    w_rptr_d;
    logic [CW-1:0]    w_count_d;
    logic             w_full;
    logic             w_empty;
    logic             w_push;
    logic             w_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign w_full  = (r_count == CW'(DEPTH));
    assign w_empty = (r_count == '0);
    assign w_push  = bus.in_valid && !w_full;
    assign w_pop   = !w_empty && bus.out_ready;

    always_comb begin
        w_res = '0;
        unique case (bus.in_op)
            2'd0: w_res = bus.in_a & bus.in_b;
            2'd1: w_res = bus.in_a | bus.in_b;
            2'd2: w_res = bus.in_a ^ bus.in_b;
            2'd3: w_res = ~bus.in_a;
        endcase
    end

    always_comb begin
        w_rptr_d  = w_pop ? ptr_inc(r_rptr) : r_rptr;
        w_wptr_d  = w_push ? ptr_inc(r_wptr) : r_wptr;
        w_count_d = r_count;
        if (w_push && !w_pop) begin
            w_count_d = r_count + CW'(1);
        end else if (w_pop && !w_push) begin
            w_count_d = r_count - CW'(1);
        end
        // Next head comes from the incoming result when it lands in the slot rptr will point at.
        w_head_d = r_head;
        if (w_count_d != '0) begin
            if (w_push && (r_wptr == w_rptr_d)) begin
                w_head_d = w_res;
            end else begin
                w_head_d = r_mem[w_rptr_d];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= w_res;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_head     <= '0;
            r_xfer_cnt <= '0;
        end else begin
            r_wptr  <= w_wptr_d;
            r_rptr  <= w_rptr_d;
            r_count <= w_count_d;
            r_head  <= w_head_d;
            if (w_pop && (r_xfer_cnt != '1)) begin
                r_xfer_cnt <= r_xfer_cnt + 1'b1;
            end
        end
    end

    assign bus.in_ready  = !w_full;
    assign bus.out_valid = !w_empty;
    assign bus.out_data  = r_head;
    assign bus.xfer_cnt  = r_xfer_cnt;

`ifdef GATE_LANE_PIPE_PARITY_EN
    logic [CH-1:0] r_par;
    logic [CH-1:0] w_par_d;

    always_comb begin
        w_par_d = '0;
        for (int unsigned i = 0; i < CH; i++) begin
            w_par_d[i] = ^w_head_d[i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_par <= '0;
        end else begin
            r_par <= w_par_d;
        end
    end

    assign bus.out_par = r_par;
`endif
endmodule
